// File: rtl/vital_energy_bank_if.sv
// Request/status bundle for the vital energy bank: per-channel controls in,
// packed counter values, levels and flags out.
interface vital_energy_bank_if #(
  parameter int CH         = 2,
  parameter int N          = 8,
  parameter int LEVEL_BITS = 2,
  parameter int PW         = 8
);
  logic [CH-1:0]            inc;
  logic [CH-1:0]            dec;
  logic [CH-1:0]            fast;
  logic [CH-1:0]            setval;
  logic                     decay_en;
  logic [PW-1:0]            decay_period;
  logic [CH*N-1:0]          value;
  logic [CH*LEVEL_BITS-1:0] level;
  logic [CH-1:0]            zero;
  logic [CH-1:0]            full;
  logic [CH-1:0]            depleted;

  modport master (
    output inc, dec, fast, setval, decay_en, decay_period,
    input  value, level, zero, full, depleted
  );

  modport slave (
    input  inc, dec, fast, setval, decay_en, decay_period,
    output value, level, zero, full, depleted
  );
endinterface

// File: rtl/vital_energy_bank.sv
// CH independent saturating energy counters with a shared decay prescaler,
// hysteretic quantised levels, zero/full flags and one-shot depletion pulses.
module vital_energy_bank #(
  parameter int CH          = 2,
  parameter int N           = 8,
  parameter int SET_VAL     = 64,
  parameter int DEFAULT_VAL = 128,
  parameter int FAST_STEP   = 4,
  parameter int LEVEL_BITS  = 2,
  parameter int HYST        = 4,
  parameter int PW          = 8
) (
  input logic               clk,
  input logic               rst_n,
  vital_energy_bank_if.slave bus
);

  localparam int                    S        = N - LEVEL_BITS;
  localparam logic [N:0]            MAX_V    = {1'b0, {N{1'b1}}};
  localparam logic [N:0]            FAST_W   = (N+1)'(FAST_STEP);
  localparam logic [N+1:0]          HYST_W   = (N+2)'(HYST);
  localparam logic [LEVEL_BITS-1:0] LMAX     = '1;
  localparam logic [LEVEL_BITS-1:0] LVL_RST  = LEVEL_BITS'(DEFAULT_VAL >> S);
  localparam logic                  ZERO_RST = (DEFAULT_VAL == 0);

  logic [PW-1:0]         presc;
  logic                  decay_tick;
  logic [N-1:0]          val_q  [CH];
  logic [N-1:0]          val_d  [CH];
  logic [LEVEL_BITS-1:0] lvl_q  [CH];
  logic [LEVEL_BITS-1:0] lvl_d  [CH];
  logic [N:0]            step   [CH];
  logic [N:0]            sum    [CH];
  logic [N:0]            diff   [CH];
  logic [N+1:0]          val_ext[CH];
  logic [N+1:0]          up_th  [CH];
  logic [N+1:0]          dn_th  [CH];
  logic [CH-1:0]         zero;
  logic [CH-1:0]         prev_zero;

  always_comb decay_tick = bus.decay_en && (presc == bus.decay_period);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)              presc <= '0;
    else if (!bus.decay_en) presc <= '0;
    else if (decay_tick)    presc <= '0;
    else                    presc <= presc + 1'b1;
  end

  // Sums and differences carry one extra bit so saturation is a simple
  // overflow/borrow test rather than a wrap.
  always_comb begin
    for (int unsigned c = 0; c < CH; c++) begin
      step[c]    = bus.fast[c] ? FAST_W : (N+1)'(1);
      sum[c]     = {1'b0, val_q[c]} + step[c];
      diff[c]    = {1'b0, val_q[c]} - step[c];
      val_ext[c] = (N+2)'(val_q[c]);
      up_th[c]   = (((N+2)'(lvl_q[c]) + (N+2)'(1)) << S) + HYST_W;
      dn_th[c]   = (N+2)'(lvl_q[c]) << S;

      val_d[c] = val_q[c];
      if (bus.setval[c])
        val_d[c] = N'(SET_VAL);
      else if (bus.inc[c] && !bus.dec[c])
        val_d[c] = (sum[c] > MAX_V) ? '1 : sum[c][N-1:0];
      else if (bus.dec[c] && !bus.inc[c])
        val_d[c] = diff[c][N] ? '0 : diff[c][N-1:0];
      else if (!bus.inc[c] && !bus.dec[c] && decay_tick && val_q[c] != '0)
        val_d[c] = val_q[c] - 1'b1;

      lvl_d[c] = lvl_q[c];
      if (lvl_q[c] != LMAX && val_ext[c] >= up_th[c])
        lvl_d[c] = lvl_q[c] + 1'b1;
      else if (lvl_q[c] != '0 && (val_ext[c] + HYST_W) < dn_th[c])
        lvl_d[c] = lvl_q[c] - 1'b1;

      zero[c] = (val_q[c] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned c = 0; c < CH; c++) begin
        val_q[c] <= N'(DEFAULT_VAL);
        lvl_q[c] <= LVL_RST;
      end
      prev_zero <= {CH{ZERO_RST}};
    end else begin
      for (int unsigned c = 0; c < CH; c++) begin
        val_q[c] <= val_d[c];
        lvl_q[c] <= lvl_d[c];
      end
      prev_zero <= zero;
    end
  end

  always_comb begin
    bus.value    = '0;
    bus.level    = '0;
    bus.full     = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      bus.value[c*N +: N]                   = val_q[c];
      bus.level[c*LEVEL_BITS +: LEVEL_BITS] = lvl_q[c];
      bus.full[c]                           = (val_q[c] == '1);
    end
    bus.zero     = zero;
    bus.depleted = zero & ~prev_zero;
  end

endmodule

// File: tb/tb_vital_energy_bank.sv
// Directed bench for vital_energy_bank: a vector table for single-cycle
// updates plus hand sequences for saturation, decay and hysteresis.
module tb_vital_energy_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vital_energy_bank_if #(.CH(2), .N(8), .LEVEL_BITS(2), .PW(8)) bus ();

  vital_energy_bank #(
    .CH(2), .N(8), .SET_VAL(64), .DEFAULT_VAL(128), .FAST_STEP(4),
    .LEVEL_BITS(2), .HYST(4), .PW(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0] inc;
    logic [1:0] dec;
    logic [1:0] fast;
    logic [1:0] setval;
    int         v0;
    int         v1;
    logic [3:0] lvl;
  } vec_t;

  vec_t vt[7];

  function automatic int getv(input int c);
    return int'(bus.value[c*8 +: 8]);
  endfunction

  function automatic int getl(input int c);
    return int'(bus.level[c*2 +: 2]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inc = '0; bus.dec = '0; bus.fast = '0; bus.setval = '0;
  endtask

  task automatic steps(input int c, input bit up, input bit fst, input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      if (up) bus.inc[c] = 1'b1;
      else    bus.dec[c] = 1'b1;
      bus.fast[c] = fst;
      tick();
    end
    idle();
  endtask

  // Reaches target from the known SET_VAL starting point, no decay active.
  task automatic load(input int c, input int target);
    idle();
    bus.setval[c] = 1'b1;
    tick();
    idle();
    if (target >= 64) begin
      steps(c, 1'b1, 1'b1, (target - 64) / 4);
      steps(c, 1'b1, 1'b0, (target - 64) % 4);
    end else begin
      steps(c, 1'b0, 1'b1, (64 - target) / 4);
      steps(c, 1'b0, 1'b0, (64 - target) % 4);
    end
  endtask

  initial begin
    int exp_v;
    idle();
    bus.decay_en = 1'b0;
    bus.decay_period = '0;

    vt[0] = '{2'b00, 2'b00, 2'b00, 2'b00, 128, 128, 4'b1010};
    vt[0] = '{2'b01, 2'b00, 2'b00, 2'b00, 129, 128, 4'b1010};
    vt[1] = '{2'b01, 2'b10, 2'b11, 2'b00, 133, 124, 4'b1010};
    vt[2] = '{2'b11, 2'b11, 2'b00, 2'b01,  64, 124, 4'b1010};
    vt[3] = '{2'b10, 2'b01, 2'b01, 2'b00,  60, 125, 4'b1001};
    vt[4] = '{2'b00, 2'b00, 2'b00, 2'b00,  60, 125, 4'b1001};
    vt[5] = '{2'b00, 2'b01, 2'b00, 2'b00,  59, 125, 4'b1001};
    vt[6] = '{2'b00, 2'b00, 2'b00, 2'b00,  59, 125, 4'b1000};

    #12;
    chk("rst_v0", getv(0), 128);
    chk("rst_v1", getv(1), 128);
    chk("rst_lvl", int'(bus.level), 4'b1010);
    chk("rst_zero", int'(bus.zero), 0);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_dep", int'(bus.depleted), 0);
    @(negedge clk);
    rst_n = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus.inc = vt[i].inc; bus.dec = vt[i].dec;
      bus.fast = vt[i].fast; bus.setval = vt[i].setval;
      tick();
      chk($sformatf("vec%0d_v0", i), getv(0), vt[i].v0);
      chk($sformatf("vec%0d_v1", i), getv(1), vt[i].v1);
      chk($sformatf("vec%0d_lvl", i), int'(bus.level), int'(vt[i].lvl));
      chk($sformatf("vec%0d_zf", i), int'({bus.zero, bus.full, bus.depleted}), 0);
    end
    idle();

    // Saturation at both ends and single-cycle depletion pulse
    load(0, 250);
    load(1, 2);
    chk("load_v0", getv(0), 250);
    chk("load_v1", getv(1), 2);
    bus.inc[0] = 1'b1; bus.fast[0] = 1'b1;
    bus.dec[1] = 1'b1; bus.fast[1] = 1'b1;
    tick();
    chk("sat1_v0", getv(0), 254);
    chk("sat1_full", int'(bus.full), 0);
    chk("sat1_v1", getv(1), 0);
    chk("sat1_zero", int'(bus.zero), 2);
    chk("sat1_dep", int'(bus.depleted), 2);
    tick();
    chk("sat2_v0", getv(0), 255);
    chk("sat2_full", int'(bus.full), 1);
    chk("sat2_v1", getv(1), 0);
    chk("sat2_dep", int'(bus.depleted), 0);
    tick();
    chk("sat3_v0", getv(0), 255);
    chk("sat3_zero", int'(bus.zero), 2);
    chk("sat3_dep", int'(bus.depleted), 0);

    // setval wins over inc/dec; level walks down one band per cycle
    idle();
    bus.setval[0] = 1'b1; bus.inc[0] = 1'b1; bus.dec[0] = 1'b1;
    tick();
    idle();
    chk("setv_v0", getv(0), 64);
    chk("setv_l0", getl(0), 3);
    tick();
    chk("walk1_l0", getl(0), 2);
    tick();
    chk("walk2_l0", getl(0), 1);
    tick();
    chk("walk3_l0", getl(0), 1);

    load(0, 100);
    bus.inc[0] = 1'b1; bus.dec[0] = 1'b1;
    tick();
    idle();
    chk("incdec_hold", getv(0), 100);

    // Decay every 4th cycle, tick lost on a channel with a request
    load(0, 10);
    load(1, 10);
    bus.decay_period = 8'd3;
    bus.decay_en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_v = (k < 4) ? 10 : (k < 8) ? 9 : 8;
      chk($sformatf("decay%0d_v0", k), getv(0), exp_v);
      chk($sformatf("decay%0d_v1", k), getv(1), exp_v);
    end
    bus.inc[0] = 1'b1;
    tick();
    idle();
    chk("lost_tick_v0", getv(0), 9);
    chk("lost_tick_v1", getv(1), 7);
    bus.decay_en = 1'b0;
    tick();
    chk("decay_off_v1", getv(1), 7);
    bus.decay_period = 8'd0;
    bus.decay_en = 1'b1;
    tick();
    chk("p0a_v0", getv(0), 8);
    chk("p0a_v1", getv(1), 6);
    tick();
    chk("p0b_v0", getv(0), 7);
    chk("p0b_v1", getv(1), 5);
    bus.decay_en = 1'b0;

    // Hysteresis around band edges 192 and 128
    load(0, 195);
    tick();
    tick();
    chk("hy195_v", getv(0), 195);
    chk("hy195_l", getl(0), 2);
    steps(0, 1'b1, 1'b0, 1);
    chk("hy196_v", getv(0), 196);
    chk("hy196_lag", getl(0), 2);
    tick();
    chk("hy196_l", getl(0), 3);
    steps(0, 1'b0, 1'b0, 6);
    tick();
    chk("hy190_v", getv(0), 190);
    chk("hy190_l", getl(0), 3);
    steps(0, 1'b0, 1'b0, 3);
    chk("hy187_lag", getl(0), 3);
    tick();
    chk("hy187_l", getl(0), 2);
    steps(0, 1'b0, 1'b1, 15);
    steps(0, 1'b0, 1'b0, 3);
    tick();
    chk("hy124_v", getv(0), 124);
    chk("hy124_l", getl(0), 2);
    steps(0, 1'b0, 1'b0, 1);
    chk("hy123_lag", getl(0), 2);
    tick();
    chk("hy123_l", getl(0), 1);

    // Asynchronous reset mid-count
    bus.inc[0] = 1'b1; bus.fast[0] = 1'b1;
    tick();
    #3 rst_n = 1'b1;
    #1;
    chk("arst_v0", getv(0), 128);
    chk("arst_v1", getv(1), 128);
    chk("arst_lvl", int'(bus.level), 4'b1010);
    chk("arst_dep", int'(bus.depleted), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("post_rst_v0", getv(0), 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vital_energy_bank.md
Name: vital_energy_bank

Overview:
- Multi-channel, parametrised successor to the single vital-energy resource. It holds CH independent saturating energy counters.
- Each counter has per-channel inc/dec/fast/setval controls and shared programmable passive decay.
- Outputs per channel: a hysteretic quantised level, zero/full flags and a one-shot depletion event.
- Sits between the energy regulators and the mood/sleep logic, so those blocks see no level chatter near band boundaries.

Parameters:
- CH, 2, number of independent energy channels
- N, 8, counter width per channel
- SET_VAL, 64, value loaded on setval
- DEFAULT_VAL, 128, reset value of every counter
- FAST_STEP, 4, step size when fast is asserted (must be < 2^N)
- LEVEL_BITS, 2, width of quantised level output (must be <= N)
- HYST, 4, hysteresis margin in counts around level band edges
- PW, 8, width of decay_period

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1)
- inc  in  CH  per-channel increment request
- dec  in  CH  per-channel decrement request
- fast  in  CH  per-channel: step = FAST_STEP instead of 1
- setval  in  CH  per-channel load of SET_VAL
- decay_en  in  1  enable passive decay
- decay_period  in  PW  decay tick interval minus one
- value  out  CH*N  counters, channel c at [c*N +: N]
- level  out  CH*LEVEL_BITS  hysteretic level, channel c at [c*LEVEL_BITS +: LEVEL_BITS]
- zero  out  CH  value == 0
- full  out  CH  value == 2^N-1
- depleted  out  CH  one-cycle pulse on nonzero-to-zero transition

Behaviour:
- Reset (async, rst_n=1):
  - every value = DEFAULT_VAL
  - level = DEFAULT_VAL >> (N-LEVEL_BITS)
  - prescaler = 0
  - prev_zero = (DEFAULT_VAL == 0), so depleted = 0 during and after reset
  - Reset mid-operation aborts everything; outputs show reset values immediately.
- Per-channel update priority, evaluated each clk edge:
  1. setval: value <= SET_VAL, regardless of inc/dec/decay.
  2. inc & ~dec: value <= min(value + step, 2^N-1).
  3. dec & ~inc: value <= max(value - step, 0).
  4. inc & dec: hold.
  5. Neither, and decay_tick: value <= max(value - 1, 0).
  6. Otherwise hold.
- step = fast ? FAST_STEP : 1.
- Arithmetic is done in N+1 bits, then clamped. No wrap-around ever.
- Decay prescaler (shared, PW bits):
  - decay_en = 0: prescaler <= 0, decay_tick = 0.
  - decay_en = 1: decay_tick = (prescaler == decay_period). On a tick the prescaler returns to 0; otherwise it increments.
  - decay_period = 0 gives a tick every cycle; decay_period = D gives a tick every D+1 cycles.
  - The first tick comes D+1 cycles after decay_en rises.
  - A decay_period change takes effect on the next comparison.
- A decay tick is lost on any channel that has inc, dec or setval asserted in that cycle. Other channels still decay.
- Level hysteresis (registered; lags value by one cycle):
  - S = N-LEVEL_BITS; L = current level; Lmax = 2^LEVEL_BITS-1.
  - Move up: L < Lmax and value >= ((L+1) << S) + HYST → L <= L+1.
  - Move down: L > 0 and value + HYST < (L << S) → L <= L-1.
  - Comparisons are done in N+2 bits.
  - Level changes at most one step per cycle. A large jump converges over several cycles.
- zero and full are combinational from the value registers.
- depleted = zero & ~prev_zero, with prev_zero <= zero each clk. The pulse is exactly one cycle, in the first cycle value reads 0. Remaining at 0 gives no further pulses.
- Channels are fully independent except for the shared decay tick.

Test Plan:
- Reset with CH=2, N=8 defaults → both values 128, level 2, zero=0, full=0, depleted=0. Asserting rst_n mid-count restores 128 asynchronously, before the next clk edge.
- Ch0 inc+fast held from 250 → 254, then 255 and holds, full=1. Ch1 dec+fast from 2 → 0 with depleted pulse on ch1 for exactly one cycle. Holding dec further keeps 0 and no new pulse.
- Ch0 setval+inc+dec all high → 64 next cycle. inc & dec without setval from 100 → stays 100.
- decay_en=1, decay_period=3, no requests, value 10 → decrements on every 4th cycle, first after 4 cycles, reaching 9, 8, ... Pulsing ch0 inc on a tick cycle → ch0 +1 with that tick lost, ch1 still decays.
- Hysteresis at level 2:
  - step to 195 → level stays 2
  - 196 → level 3 one cycle later
  - back to 190 → stays 3
  - 187 → level 2
  - 124 → stays 2
  - 123 → level 1
- setval from 255 with level 3 → value 64 immediately; level walks 3→2→1 over two cycles, then holds 1.
